// File: rtl/dsp_block_engine.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_block_engine
//  Purpose  : Streams one block out of a ping-pong source bank, applies a
//             runtime-selected arithmetic operation per sample, and writes the
//             results to the destination bank at the same addresses.
//  Ports    : clk, rst_n               - clock, async active-low reset
//             mode, coef, len          - operation, operand, block length
//                                        (sampled at block start)
//             src_ready, dst_ready     - bank handshake from ping-pong control
//             src_addr / src_data      - source bank read port (READ_LAT)
//             dst_addr/dst_data/dst_we - destination bank write port
//             src_done, dst_done       - one-cycle bank release strobes
//             aborted                  - one-cycle strobe, block abandoned
//             busy                     - engine not idle
//  Revision : 1.0 - initial release
// ============================================================================
module dsp_block_engine #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 7,
   parameter int READ_LAT = 1,
   parameter int FRAC_W   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] coef,
   input  logic [ADDR_W:0]   len,
   input  logic              src_ready,
   input  logic              dst_ready,
   output logic [ADDR_W-1:0] src_addr,
   input  logic [DATA_W-1:0] src_data,
   output logic [ADDR_W-1:0] dst_addr,
   output logic [DATA_W-1:0] dst_data,
   output logic              dst_we,
   output logic              src_done,
   output logic              dst_done,
   output logic              aborted,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] c_max_len = {1'b1, {ADDR_W{1'b0}}};

   state_t                  state;
   state_t                  state_nxt;

   logic [1:0]              r_mode;
   logic [DATA_W-1:0]       r_coef;
   logic [ADDR_W-1:0]       r_last;
   logic [READ_LAT-1:0]     r_vld;
   logic [ADDR_W-1:0]       r_apipe [READ_LAT];

   logic                    w_rdy;
   logic                    w_start;
   logic                    w_launch;
   logic                    w_issue;
   logic                    w_abort;
   logic                    w_last;
   logic                    w_drained;
   logic [ADDR_W-1:0]       w_last_addr;
   logic [DATA_W:0]         w_sum;
   logic [2*DATA_W-1:0]     w_prod;
   logic [2*DATA_W-1:0]     w_prod_sh;
   logic [DATA_W-1:0]       w_result;

   assign w_rdy     = src_ready & dst_ready;
   assign w_start   = w_rdy & (len != '0);
   assign w_launch  = ((state == IDLE) || (state == DONE)) && w_start;
   assign w_issue   = (state == READ) && w_rdy;
   assign w_abort   = (state == READ) && !w_rdy;
   assign w_last    = w_issue && (src_addr == r_last);
   // Contiguous writes mean the final write is the one seen once no valid
   // sample is left in the read-latency pipeline.
   assign w_drained = (state == DRAIN) && dst_we && (r_vld == '0);

   // Oversized lengths clamp to a full bank; the last address is then all ones.
   // A length of exactly 2^ADDR_W has zero low bits, so minus one also wraps to
   // all ones.
   assign w_last_addr = (len > c_max_len) ? {ADDR_W{1'b1}}
                                          : len[ADDR_W-1:0] - ADDR_W'(1);

   assign dst_done = (state == DONE);
   assign busy     = (state != IDLE);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (w_start) state_nxt = READ;
         READ:  begin
                   if (w_abort)     state_nxt = IDLE;
                   else if (w_last) state_nxt = DRAIN;
                end
         DRAIN: if (w_drained) state_nxt = DONE;
         DONE:  state_nxt = w_start ? READ : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- control
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_addr <= '0;
         r_last   <= '0;
         r_mode   <= 2'd0;
         r_coef   <= '0;
         src_done <= 1'b0;
         aborted  <= 1'b0;
      end else begin
         src_done <= w_last;
         aborted  <= w_abort;
         if (w_launch) begin
            src_addr <= '0;
            r_last   <= w_last_addr;
            r_mode   <= mode;
            r_coef   <= coef;
         end else if (state == READ) begin
            // Return to 0 after the last address so the counter never wraps.
            if (w_abort || w_last) src_addr <= '0;
            else                   src_addr <= src_addr + ADDR_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------- read-latency tags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         for (int i = 0; i < READ_LAT; i++) r_apipe[i] <= '0;
      end else begin
         if (w_abort) begin
            r_vld <= '0;
         end else begin
            r_vld[0] <= w_issue;
            for (int i = 1; i < READ_LAT; i++) r_vld[i] <= r_vld[i-1];
         end
         r_apipe[0] <= src_addr;
         for (int i = 1; i < READ_LAT; i++) r_apipe[i] <= r_apipe[i-1];
      end
   end

   // ---------------------------------------------------------------- arithmetic
   assign w_sum     = {1'b0, src_data} + {1'b0, r_coef};
   assign w_prod    = {{DATA_W{1'b0}}, src_data} * {{DATA_W{1'b0}}, r_coef};
   assign w_prod_sh = w_prod >> FRAC_W;

   always_comb begin
      w_result = src_data;
      case (r_mode)
         2'd0: w_result = src_data;
         2'd1: w_result = w_sum[DATA_W-1:0];
         2'd2: w_result = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
         2'd3: w_result = (|w_prod_sh[2*DATA_W-1:DATA_W]) ? {DATA_W{1'b1}}
                                                           : w_prod_sh[DATA_W-1:0];
         default: w_result = src_data;
      endcase
   end

   // ---------------------------------------------------------------- write stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dst_we   <= 1'b0;
         dst_addr <= '0;
         dst_data <= '0;
      end else begin
         dst_we <= r_vld[READ_LAT-1] && !w_abort;
         if (r_vld[READ_LAT-1] && !w_abort) begin
            dst_addr <= r_apipe[READ_LAT-1];
            dst_data <= w_result;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dsp_block_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dsp_block_engine
//  Purpose  : Scoreboard bench for dsp_block_engine. Stimulus pushes expected
//             writes and strobe cycles; a negedge monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_block_engine;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 7;
   localparam int LAT    = 2;
   localparam int FRAC   = 2;
   localparam int LW     = ADDR_W + 1;
   localparam int NMAX   = 1 << ADDR_W;
   localparam int DMAX   = (1 << DATA_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [1:0]        mode = '0;
   logic [DATA_W-1:0] coef = '0;
   logic [ADDR_W:0]   len = '0;
   logic              src_ready = 1'b0;
   logic              dst_ready = 1'b0;
   logic [ADDR_W-1:0] src_addr;
   logic [DATA_W-1:0] src_data;
   logic [ADDR_W-1:0] dst_addr;
   logic [DATA_W-1:0] dst_data;
   logic              dst_we, src_done, dst_done, aborted, busy;

   dsp_block_engine #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(LAT), .FRAC_W(FRAC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .coef(coef), .len(len),
      .src_ready(src_ready), .dst_ready(dst_ready),
      .src_addr(src_addr), .src_data(src_data),
      .dst_addr(dst_addr), .dst_data(dst_data), .dst_we(dst_we),
      .src_done(src_done), .dst_done(dst_done), .aborted(aborted), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Source bank with LAT cycles of read latency.
   logic [DATA_W-1:0] mem  [NMAX];
   logic [ADDR_W-1:0] hist [LAT];
   always @(posedge clk) begin
      hist[0] <= src_addr;
      for (int i = 1; i < LAT; i++) hist[i] <= hist[i-1];
   end
   assign src_data = mem[hist[LAT-1]];

   typedef struct {int addr; int data; int cyc;} wr_t;
   wr_t wq[$];
   int  sdq[$];
   int  ddq[$];
   int  abq[$];
   int  total = 0;
   int  bad   = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      total++;
      bad++;
      $display("FAIL %s: pulse/write at cycle %0d with none required", name, cyc);
   endtask

   function automatic int ref_op(input int m, input int c, input int x);
      int p;
      case (m)
         0: return x;
         1: return (x + c) % (DMAX + 1);
         2: return (x + c > DMAX) ? DMAX : x + c;
         default: begin
            p = (x * c) >> FRAC;
            return (p > DMAX) ? DMAX : p;
         end
      endcase
   endfunction

   // ------------------------------------------------------------- monitor
   always @(negedge clk) begin : monitor
      wr_t e;
      if (rst_n) begin
         if (dst_we) begin
            if (wq.size() == 0) unexpected("write");
            else begin
               e = wq.pop_front();
               check("write_addr",  int'(dst_addr), e.addr);
               check("write_data",  int'(dst_data), e.data);
               check("write_cycle", cyc, e.cyc);
            end
         end
         if (src_done) begin
            if (sdq.size() == 0) unexpected("src_done");
            else check("src_done_cycle", cyc, sdq.pop_front());
         end
         if (dst_done) begin
            if (ddq.size() == 0) unexpected("dst_done");
            else check("dst_done_cycle", cyc, ddq.pop_front());
         end
         if (aborted) begin
            if (abq.size() == 0) unexpected("aborted");
            else check("aborted_cycle", cyc, abq.pop_front());
         end
      end
   end

   // ------------------------------------------------------------- stimulus helpers
   // base = cycle of the start edge; src_addr=0 appears in base+1.
   task automatic expect_block(input int m, input int c, input int l, input int base);
      int  n;
      wr_t e;
      n = (l > NMAX) ? NMAX : l;
      for (int k = 0; k < n; k++) begin
         e.addr = k;
         e.data = ref_op(m, c, int'(mem[k]));
         e.cyc  = base + k + LAT + 2;
         wq.push_back(e);
      end
      sdq.push_back(base + n + 1);
      ddq.push_back(base + n + LAT + 2);
   endtask

   task automatic wait_src_done();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (src_done) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL src_done_timeout: no src_done within 400 cycles");
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL idle_timeout: busy still high after 400 cycles");
      end
   endtask

   task automatic finish_block();
      check("pending_writes",   wq.size(),  0);
      check("pending_src_done", sdq.size(), 0);
      check("pending_dst_done", ddq.size(), 0);
      check("pending_aborted",  abq.size(), 0);
   endtask

   task automatic drive(input int m, input int c, input int l);
      mode = 2'(m);
      coef = DATA_W'(c);
      len  = LW'(l);
   endtask

   task automatic run_block(input int m, input int c, input int l);
      int base;
      @(negedge clk);
      drive(m, c, l);
      src_ready = 1'b1;
      dst_ready = 1'b1;
      base = cyc;
      expect_block(m, c, l, base);
      @(negedge clk);
      // Operands must already be latched; scramble them.
      drive(int'($urandom_range(0, 3)), int'($urandom_range(0, DMAX)), int'($urandom_range(0, 255)));
      wait_src_done();
      src_ready = 1'b0;
      dst_ready = 1'b0;
      wait_idle();
      finish_block();
   endtask

   task automatic run_b2b(input int m1, input int c1, input int l1,
                          input int m2, input int c2, input int l2);
      int base1, n1;
      @(negedge clk);
      drive(m1, c1, l1);
      src_ready = 1'b1;
      dst_ready = 1'b1;
      base1 = cyc;
      expect_block(m1, c1, l1, base1);
      wait_src_done();
      src_ready = 1'b0;
      @(negedge clk);
      // Readiness during DRAIN is ignored; the DONE edge starts block two.
      drive(m2, c2, l2);
      src_ready = 1'b1;
      n1 = (l1 > NMAX) ? NMAX : l1;
      expect_block(m2, c2, l2, base1 + n1 + LAT + 2);
      wait_src_done();
      src_ready = 1'b0;
      dst_ready = 1'b0;
      wait_idle();
      finish_block();
   endtask

   task automatic fill_random();
      for (int k = 0; k < NMAX; k++) mem[k] = DATA_W'($urandom);
   endtask

   task automatic check_outputs_zero(input string name);
      check(name, int'({src_addr, dst_addr, dst_data, dst_we, src_done,
                        dst_done, aborted, busy}), 0);
   endtask

   // ------------------------------------------------------------- main
   initial begin : main
      int base;
      for (int i = 0; i < LAT; i++) hist[i] = '0;
      fill_random();

      repeat (3) @(negedge clk);
      check_outputs_zero("reset_outputs");
      rst_n = 1'b1;

      // Basic block
      for (int k = 0; k < 8; k++) mem[k] = DATA_W'(8'h10 + k);
      run_block(1, 1, 8);

      // Wrap / saturate / pass
      mem[0] = 8'hFE; mem[1] = 8'hFF;
      run_block(1, 3, 2);
      run_block(2, 3, 2);
      run_block(0, 3, 2);

      // Multiply
      mem[0] = 8'h40; mem[1] = 8'h90;
      run_block(3, 2, 2);
      mem[0] = 8'h90; mem[1] = 8'h0C;
      run_block(3, 8'h10, 2);

      // Abort when src_addr=3: only writes completing by that cycle survive.
      fill_random();
      @(negedge clk);
      drive(1, 5, 8);
      src_ready = 1'b1;
      dst_ready = 1'b1;
      base = cyc;
      for (int k = 0; k < 8; k++) begin
         if (base + k + LAT + 2 <= base + 4) begin
            wr_t e;
            e.addr = k; e.data = ref_op(1, 5, int'(mem[k])); e.cyc = base + k + LAT + 2;
            wq.push_back(e);
         end
      end
      abq.push_back(base + 5);
      repeat (4) @(negedge clk);
      check("abort_src_addr", int'(src_addr), 3);
      dst_ready = 1'b0;
      @(negedge clk);
      check("busy_after_abort", int'(busy), 0);
      src_ready = 1'b0;
      repeat (5) @(negedge clk);
      finish_block();
      run_block(2, 8'h80, 8);

      // len = 0 never starts
      @(negedge clk);
      drive(0, 0, 0);
      src_ready = 1'b1;
      dst_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("len0_busy", int'(busy), 0);
      end
      src_ready = 1'b0;
      dst_ready = 1'b0;

      // Clamped length and single-sample block
      fill_random();
      run_block(1, 7, 200);
      run_block(3, 9, 1);

      // Randomised blocks
      for (int b = 0; b < 6; b++) begin
         fill_random();
         run_block(int'($urandom_range(0, 3)), int'($urandom_range(0, DMAX)),
                   int'($urandom_range(1, 40)));
      end

      // Back-to-back
      fill_random();
      run_b2b(2, 8'h40, 12, 3, 8'h21, 9);

      // Reset during READ, then clean restart
      fill_random();
      @(negedge clk);
      drive(1, 2, 20);
      src_ready = 1'b1;
      dst_ready = 1'b1;
      base = cyc;
      expect_block(1, 2, 20, base);
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_outputs_zero("async_reset_outputs");
      wq.delete(); sdq.delete(); ddq.delete(); abq.delete();
      src_ready = 1'b0;
      dst_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_outputs_zero("held_reset_outputs");
      rst_n = 1'b1;
      run_b2b(0, 0, 5, 1, 8'hF0, 6);

      repeat (5) @(negedge clk);
      finish_block();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/dsp_block_engine.md
# dsp_block_engine

Parametrised block-processing engine between two ping-pong RAM banks. When the source bank holds a full block and the destination bank is free, it streams the block out of the source bank and applies a runtime-selected arithmetic operation to each sample. It writes the results into the destination bank at the same addresses and pulses per-bank completion strobes for the ping-pong controller. It adds runtime length, mode select, read-latency compensation and abort handling.

## Interface
- DATA_W, 8: sample width.
- ADDR_W, 7: bank address width; maximum block length 2^ADDR_W.
- READ_LAT, 1: source RAM read latency in cycles (≥1).
- FRAC_W, 0: right shift applied to the product in multiply mode (0..DATA_W).

Ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  2  0 pass, 1 add wrap, 2 add saturate, 3 multiply; sampled at block start.
- coef  in  DATA_W  operand for modes 1–3; sampled at block start.
- len  in  ADDR_W+1  block length; sampled at block start.
- src_ready  in  1  source bank holds a full block.
- dst_ready  in  1  destination bank is free.
- src_addr  out  ADDR_W  source read address.
- src_data  in  DATA_W  source read data, READ_LAT cycles after src_addr.
- dst_addr  out  ADDR_W  destination write address.
- dst_data  out  DATA_W  destination write data.
- dst_we  out  1  destination write enable.
- src_done  out  1  one-cycle pulse; source bank may be released.
- dst_done  out  1  one-cycle pulse; destination bank holds the complete result.
- aborted  out  1  one-cycle pulse; block abandoned.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE → READ: at an edge where src_ready=1, dst_ready=1 and len≠0. The same edge latches mode, coef and len, and sets src_addr=0.
  - len=0: no block starts.
  - len>2^ADDR_W: clamped to 2^ADDR_W.
- READ: src_addr increments by 1 each cycle from 0 to len−1. After the last address is issued, FSM → DRAIN and src_done pulses.
- READ abort: if src_ready=0 or dst_ready=0 at any READ edge:
  - FSM → IDLE and aborted pulses.
  - The in-flight pipeline is flushed; dst_we stays low from the next cycle.
  - No done pulses are generated.
- DRAIN: waits until the last write has been issued. Ready inputs are ignored in this state.
- DONE: one cycle with dst_done=1, then FSM → IDLE.
- Datapath: a valid shift register of depth READ_LAT tags returning data, followed by one registered processing stage that drives dst_addr, dst_data and dst_we.
- Arithmetic (all operands unsigned):
  - mode 0: out = in.
  - mode 1: out = (in+coef) mod 2^DATA_W.
  - mode 2: out = min(in+coef, 2^DATA_W−1).
  - mode 3: p = (in·coef) >> FRAC_W over 2·DATA_W bits; out = p if p < 2^DATA_W, else 2^DATA_W−1.
- src_addr holds 0 in IDLE.

## Timing
- Reset values: every output is 0, FSM is IDLE and the valid pipeline is cleared. Reset asserted mid-block zeros all outputs immediately; no done or abort pulse follows.
- Let C_k be the cycle in which src_addr=k:
  - src_data for address k is valid in C_k+READ_LAT.
  - dst_we=1 with dst_addr=k and the processed data in C_k+READ_LAT+1.
  - Issue-to-write latency is READ_LAT+1 cycles.
- src_addr=0 is the cycle after the start edge; addresses are contiguous, one per cycle, with no bubbles.
- src_done = cycle C_{len−1}+1.
- dst_done = the cycle after the last dst_we.
- Earliest next start: the edge that ends DONE, if both ready inputs are high. The controller deasserts src_ready in response to src_done.
- With READ_LAT=1, len=8 and the start edge at cycle 0:
  - src_addr 0..7 in cycles 1..8.
  - dst_we in cycles 3..10.
  - src_done in cycle 9, dst_done in cycle 11.
  - busy is high in cycles 1..11.

## Test plan
- Basic block: mode=1, coef=1, len=8, src data 0x10..0x17 → writes 0x11..0x18 to addr 0..7 in cycles 3..10; src_done at cycle 9, dst_done at cycle 11, one pulse each.
- Wrap and saturate, coef=3, data 0xFE,0xFF:
  - mode 1 → 0x01, 0x02.
  - mode 2 → 0xFF, 0xFF.
  - mode 0 → 0xFE, 0xFF.
- Multiply: mode=3, coef=2, FRAC_W=0, data 0x40, 0x90 → 0x80, 0xFF. With FRAC_W=2 and coef=0x10, 0x90 → 0xFF and 0x0C → 0x30.
- Abort: dst_ready dropped at the edge where src_addr=3 → aborted pulses once and no dst_we after the next cycle. Neither done pulse fires. The next start begins at addr 0.
- Length limits, ADDR_W=7:
  - len=0 → busy stays 0.
  - len=200 → exactly 128 writes, addr 0..127, with no address wrap.
  - len=1 → a single write, src_done one cycle after src_addr=0.
- Back-to-back blocks with READ_LAT=2, and rst_n pulsed mid-READ → correct latency on both blocks; on reset all outputs are 0 asynchronously and a clean restart follows.
